// File: rtl/alu_sequencer.sv
// Control sequencer for the shared-bus ALU: accepts one register-to-register
// instruction, then steps through operand loads, execute and write-back.
module alu_sequencer #(
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [NUM_REGS-1:0] reg_tsb_out,
  output logic [NUM_REGS-1:0] reg_in_en,
  output logic                ALU_in1,
  output logic                ALU_in2,
  output logic [3:0]          opControl,
  output logic                ALU_outen,
  output logic                ALU_tsb_out,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_EXEC, S_WB, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0]          NREGS = 5'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE   = NUM_REGS'(1);

  state_t              state_q, state_d;
  logic [15:0]         instr_q, instr_d;
  logic [NUM_REGS-1:0] reg_tsb_out_q, reg_tsb_out_d;
  logic [NUM_REGS-1:0] reg_in_en_q, reg_in_en_d;
  logic                alu_in1_q, alu_in1_d;
  logic                alu_in2_q, alu_in2_d;
  logic [3:0]          opcontrol_q, opcontrol_d;
  logic                alu_outen_q, alu_outen_d;
  logic                alu_tsb_out_q, alu_tsb_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;
  logic                bad_idx;

  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid & instr_ready;
  assign bad_idx     = ({1'b0, instr[11:8]} >= NREGS) |
                       ({1'b0, instr[7:4]}  >= NREGS) |
                       ({1'b0, instr[3:0]}  >= NREGS);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          instr_d = instr;
          state_d = bad_idx ? S_ERR : S_LOAD1;
        end
      end
      S_LOAD1: state_d = S_LOAD2;
      S_LOAD2: state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the state does.
    reg_tsb_out_d = '0;
    reg_in_en_d   = '0;
    alu_in1_d     = 1'b0;
    alu_in2_d     = 1'b0;
    alu_outen_d   = 1'b0;
    alu_tsb_out_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    busy_d        = (state_d != S_IDLE);
    opcontrol_d   = (state_d == S_IDLE) ? opcontrol_q : instr_d[15:12];
    case (state_d)
      S_LOAD1: begin
        reg_tsb_out_d = ONE << instr_d[7:4];
        alu_in1_d     = 1'b1;
      end
      S_LOAD2: begin
        reg_tsb_out_d = ONE << instr_d[3:0];
        alu_in2_d     = 1'b1;
      end
      S_EXEC:  alu_outen_d = 1'b1;
      S_WB: begin
        alu_tsb_out_d = 1'b1;
        reg_in_en_d   = ONE << instr_d[11:8];
      end
      S_DONE:  done_d = 1'b1;
      S_ERR:   err_d  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      reg_tsb_out_q <= '0;
      reg_in_en_q   <= '0;
      alu_in1_q     <= 1'b0;
      alu_in2_q     <= 1'b0;
      opcontrol_q   <= '0;
      alu_outen_q   <= 1'b0;
      alu_tsb_out_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      reg_tsb_out_q <= reg_tsb_out_d;
      reg_in_en_q   <= reg_in_en_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      opcontrol_q   <= opcontrol_d;
      alu_outen_q   <= alu_outen_d;
      alu_tsb_out_q <= alu_tsb_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign reg_tsb_out = reg_tsb_out_q;
  assign reg_in_en   = reg_in_en_q;
  assign ALU_in1     = alu_in1_q;
  assign ALU_in2     = alu_in2_q;
  assign opControl   = opcontrol_q;
  assign ALU_outen   = alu_outen_q;
  assign ALU_tsb_out = alu_tsb_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus a randomized
// run compared cycle by cycle against a "cycles since accept" reference model.
module tb_alu_sequencer;

  localparam int N  = 8;
  localparam int VW = 12 + 2 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [N-1:0]  reg_tsb_out;
  logic [N-1:0]  reg_in_en;
  logic          ALU_in1, ALU_in2, ALU_outen, ALU_tsb_out;
  logic [3:0]    opControl;
  logic          busy, done, err;

  int checks   = 0;
  int failures = 0;

  alu_sequencer #(.NUM_REGS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reg_tsb_out (reg_tsb_out),
    .reg_in_en   (reg_in_en),
    .ALU_in1     (ALU_in1),
    .ALU_in2     (ALU_in2),
    .opControl   (opControl),
    .ALU_outen   (ALU_outen),
    .ALU_tsb_out (ALU_tsb_out),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {instr_ready, busy, done, err, ALU_in1, ALU_in2, ALU_outen,
                    ALU_tsb_out, opControl, reg_tsb_out, reg_in_en};

  // Reference model: m_k counts cycles since the accepting edge (0 = idle).
  int          m_k   = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_ins = '0;
  logic [3:0]  m_op  = '0;

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] tsb, ien;
    logic d, e, i1, i2, oe, at;
    tsb = '0; ien = '0; d = 0; e = 0; i1 = 0; i2 = 0; oe = 0; at = 0;
    if (m_err) e = (m_k == 1);
    else begin
      case (m_k)
        1: begin tsb = N'(1) << m_ins[7:4]; i1 = 1; end
        2: begin tsb = N'(1) << m_ins[3:0]; i2 = 1; end
        3: oe = 1;
        4: begin at = 1; ien = N'(1) << m_ins[11:8]; end
        5: d = 1;
        default: ;
      endcase
    end
    return {m_k == 0, m_k != 0, d, e, i1, i2, oe, at, m_op, tsb, ien};
  endfunction

  task automatic model_edge();
    if (m_k == 0) begin
      if (instr_valid) begin
        m_ins = instr;
        m_op  = instr[15:12];
        m_err = (int'(instr[11:8]) >= N) || (int'(instr[7:4]) >= N) ||
                (int'(instr[3:0]) >= N);
        m_k   = 1;
      end
    end else if (m_err || m_k == 5) m_k = 0;
    else m_k++;
  endtask

  task automatic model_reset();
    m_k = 0; m_err = 0; m_ins = '0; m_op = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_valid = 1'b1; instr = 16'h2301;
    model_reset();
    repeat (3) step();
    checks++;
    if (dut_vec !== exp_vec())
      $display("FAIL reset_vec: got %h exp %h", dut_vec, exp_vec());
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || opControl !== 4'd0 || reg_in_en !== '0) begin
      failures++;
      $display("FAIL reset_outs: ready=%b busy=%b op=%h ien=%h exp ready=1 busy=0 op=0 ien=0",
               instr_ready, busy, opControl, reg_in_en);
    end
    if (dut_vec !== exp_vec()) failures++;
    reset = 1'b1; instr_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_no_accept: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    logic ok;
    instr = 16'h2301; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      case (k)
        1: ok = (reg_tsb_out === 8'h01) && ALU_in1 === 1'b1;
        2: ok = (reg_tsb_out === 8'h02) && ALU_in2 === 1'b1;
        3: ok = ALU_outen === 1'b1 && reg_tsb_out === 8'h00 && ALU_tsb_out === 1'b0;
        4: ok = ALU_tsb_out === 1'b1 && reg_in_en === 8'h08 && reg_tsb_out === 8'h00;
        5: ok = done === 1'b1 && reg_in_en === 8'h00;
        default: ok = instr_ready === 1'b1 && busy === 1'b0;
      endcase
      ok = ok && opControl === 4'd2;
      checks++;
      if (!ok || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL basic_T+%0d: got %h exp %h", k, dut_vec, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int first_load = -1, second_load = -1;
    instr = 16'h1122; instr_valid = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) instr = 16'h5467;
      if (m_k == 1 && m_ins == 16'h5467) instr_valid = 1'b0;
      if (ALU_in1 === 1'b1) begin
        if (first_load < 0) first_load = c;
        else if (second_load < 0) begin
          second_load = c;
          checks++;
          if (reg_tsb_out !== 8'h40 || opControl !== 4'd5) begin
            failures++;
            $display("FAIL b2b_second_load: tsb=%h op=%h exp tsb=40 op=5", reg_tsb_out, opControl);
          end
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_cycle%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (second_load - first_load != 6 || first_load != 1) begin
      failures++;
      $display("FAIL b2b_spacing: loads at %0d and %0d exp 1 and 7", first_load, second_load);
    end
  endtask

  task automatic test_err();
    instr = 16'h0912; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || reg_tsb_out !== '0 || reg_in_en !== '0 || ALU_in1 !== 1'b0 ||
        ALU_in2 !== 1'b0 || ALU_outen !== 1'b0 || ALU_tsb_out !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL err_pulse: got %h exp %h", dut_vec, exp_vec());
    end
    step();
    checks++;
    if (err !== 1'b0 || instr_ready !== 1'b1 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL err_return: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    instr = 16'h3444; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step();
    checks++;
    if (ALU_outen !== 1'b1) begin
      failures++;
      $display("FAIL midrst_exec: ALU_outen=%b exp 1", ALU_outen);
    end
    #3 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== exp_vec() || ALU_outen !== 1'b0 || opControl !== 4'd0) begin
      failures++;
      $display("FAIL midrst_async: got %h exp %h", dut_vec, exp_vec());
    end
    step();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (reg_in_en !== '0 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL midrst_after%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int c = 0; c < 1000; c++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 7) != 0) r = {r[15:12], 1'b0, r[10:8], 1'b0, r[6:4], 1'b0, r[2:0]};
      instr = r;
      instr_valid = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h exp %h", c, dut_vec, exp_vec());
      end
      checks++;
      if ($countones(reg_tsb_out) + int'(ALU_tsb_out) > 1 || $countones(reg_in_en) > 1) begin
        failures++;
        $display("FAIL random_bus_excl%0d: tsb=%h alu_tsb=%b ien=%h exp at most one driver",
                 c, reg_tsb_out, ALU_tsb_out, reg_in_en);
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control sequencer that sits directly upstream of the ALU datapath. It accepts one register-to-register instruction at a time through a valid/ready handshake. It then drives the shared 16-bit bus protocol in order: source register onto bus, ALU operand latch, ALU result latch, and result written back to the destination register. All bus-driver and latch enables come from this block; no other block drives the ALU control inputs.

Parameters:
NUM_REGS, 8, number of general registers on the bus; width of the one-hot register enable vectors; legal range 2..16.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
instr  input  16  instruction: [15:12] opcode, [11:8] dst index, [7:4] src1 index, [3:0] src2 index
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept an instruction
reg_tsb_out  output  NUM_REGS  one-hot output enable of register tri-state buffers onto bus
reg_in_en  output  NUM_REGS  one-hot load enable of registers from bus
ALU_in1  output  1  load ALU operand register 1 from bus
ALU_in2  output  1  load ALU operand register 2 from bus
opControl  output  4  ALU operation select
ALU_outen  output  1  load ALU output register
ALU_tsb_out  output  1  enable ALU output tri-state buffer onto bus
busy  output  1  sequence in progress
done  output  1  one-cycle pulse: write-back completed
err  output  1  one-cycle pulse: instruction rejected

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0 except instr_ready=1; latched instruction cleared to 0. Reset mid-sequence aborts immediately. No partial write-back occurs after release.
- All outputs except instr_ready are registered (Moore decode of state plus latched instruction). instr_ready = (state==IDLE), combinational.
- Accept: rising edge with instr_valid=1 and instr_ready=1 latches instr. Index check at accept: any of dst/src1/src2 >= NUM_REGS → next state ERR; otherwise → LOAD1.
- States and outputs:
  - IDLE: all enables 0, busy=0.
  - LOAD1: reg_tsb_out[src1]=1, ALU_in1=1 → LOAD2.
  - LOAD2: reg_tsb_out[src2]=1, ALU_in2=1 → EXEC.
  - EXEC: ALU_outen=1, no bus driver enabled → WB.
  - WB: ALU_tsb_out=1, reg_in_en[dst]=1 → DONE.
  - DONE: done=1, enables 0 → IDLE.
  - ERR: err=1, enables 0 → IDLE.
- busy=1 in LOAD1, LOAD2, EXEC, WB, DONE, ERR.
- opControl = latched opcode from the cycle after accept until return to IDLE. It holds its last value in IDLE and is 0 after reset.
- Latency: accept edge T. LOAD1 at T+1, WB at T+4, done=1 in cycle T+5. The next instruction can be accepted at the end of cycle T+6 (IDLE), so one instruction completes every 6 cycles.
- Bus exclusivity invariant: in every cycle, popcount(reg_tsb_out) + ALU_tsb_out <= 1. reg_in_en is at most one-hot.
- src1==src2, dst==src1 and dst==src2 are all legal. Because each operand is read in an earlier cycle than write-back, the old register value is used as the operand.
- instr_valid while busy is ignored: the instruction is not latched and there is no side effect. instr changes while busy have no effect.
- ERR path asserts no register or ALU enable at any time.

Test Plan:
- Reset with instr_valid=1 → all enables 0, instr_ready=1, busy=0, opControl=0; no accept while reset=0.
- instr=16'h2301 (op 2, dst 3, src1 0, src2 1), valid one cycle → T+1 reg_tsb_out=8'h01+ALU_in1; T+2 reg_tsb_out=8'h02+ALU_in2; T+3 ALU_outen; T+4 ALU_tsb_out+reg_in_en=8'h08; T+5 done; opControl=2 throughout.
- Back-to-back: valid held high with 16'h1122 then 16'h5467 → second accepted only when instr_ready returns; second LOAD1 starts exactly 6 cycles after the first.
- NUM_REGS=8, instr=16'h0912 (dst 9) → err pulse one cycle after accept, no enable ever asserted, instr_ready high again next cycle.
- Reset pulsed low during EXEC of 16'h3444 → outputs 0 asynchronously; after release, IDLE, and reg_in_en never asserts for that instruction.
- Random legal instructions for 1000 cycles with assertion checks → bus exclusivity invariant and one-hot reg_in_en hold every cycle.
